// File: rtl/keypad_scan_ctrl.sv
// 4x4 matrix keypad scanner: rotates the active-low column drive, synchronises
// and debounces one key at a time, and reports key code, press strobe,
// key-down level and a mode toggle bound to one designated key.
module keypad_scan_ctrl #(
   parameter int unsigned SCAN_DIV = 50_000,
   parameter int unsigned DEB_CNT  = 20,
   parameter int unsigned MODE_KEY = 15
) (
   input  logic       clk,
   input  logic       rstn,
   input  logic [3:0] row_in,
   output logic [3:0] col_out,
   output logic [3:0] key_code,
   output logic       key_valid,
   output logic       key_down,
   output logic       mode
);

   typedef enum logic [1:0] {SCAN, DEB_PRESS, PRESSED, DEB_REL} state_t;

   localparam logic [19:0] DIV_LAST = 20'(SCAN_DIV - 1);
   localparam logic [7:0]  DEB      = 8'(DEB_CNT);
   localparam logic [3:0]  MKEY     = 4'(MODE_KEY);

   state_t      state, state_n;
   logic [3:0]  r1, rs;
   logic [19:0] div;
   logic        tick;
   logic [1:0]  col, col_n;
   logic [1:0]  row_sel, row_sel_n;
   logic [1:0]  low_row, acc_row;
   logic [7:0]  deb, deb_n, deb_inc;
   logic [3:0]  code_n;
   logic        valid_n, down_n, mode_n, accept;
   logic        row_hi;

   assign tick    = (div == DIV_LAST);
   assign col_out = ~(4'b0001 << col);
   assign row_hi  = rs[row_sel];
   assign deb_inc = (deb < DEB) ? deb + 8'd1 : deb;

   // Two-flop synchroniser for the asynchronous row inputs.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r1 <= '1;
         rs <= '1;
      end else begin
         r1 <= row_in;
         rs <= r1;
      end
   end

   // Free-running scan tick divider.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)     div <= '0;
      else if (tick) div <= '0;
      else           div <= div + 20'd1;
   end

   // Lowest-index low row wins when several rows are active.
   always_comb begin
      if (!rs[0])      low_row = 2'd0;
      else if (!rs[1]) low_row = 2'd1;
      else if (!rs[2]) low_row = 2'd2;
      else             low_row = 2'd3;
   end

   // Next-state and output logic; every decision is taken on a scan tick.
   always_comb begin
      state_n   = state;
      col_n     = col;
      row_sel_n = row_sel;
      deb_n     = deb;
      code_n    = key_code;
      valid_n   = 1'b0;
      down_n    = key_down;
      mode_n    = mode;
      accept    = 1'b0;
      acc_row   = row_sel;
      if (tick) begin
         case (state)
            SCAN: begin
               if (rs == 4'hF) begin
                  col_n = col + 2'd1;
               end else begin
                  row_sel_n = low_row;
                  deb_n     = 8'd1;
                  if (DEB == 8'd1) begin
                     accept  = 1'b1;
                     acc_row = low_row;
                     state_n = PRESSED;
                  end else begin
                     state_n = DEB_PRESS;
                  end
               end
            end
            DEB_PRESS: begin
               if (!row_hi) begin
                  deb_n = deb_inc;
                  if (deb_inc >= DEB) begin
                     accept  = 1'b1;
                     state_n = PRESSED;
                  end
               end else begin
                  deb_n   = '0;
                  col_n   = col + 2'd1;
                  state_n = SCAN;
               end
            end
            PRESSED: begin
               if (row_hi) begin
                  if (DEB == 8'd1) begin
                     down_n  = 1'b0;
                     deb_n   = '0;
                     col_n   = col + 2'd1;
                     state_n = SCAN;
                  end else begin
                     deb_n   = 8'd1;
                     state_n = DEB_REL;
                  end
               end
            end
            DEB_REL: begin
               if (row_hi) begin
                  deb_n = deb_inc;
                  if (deb_inc >= DEB) begin
                     down_n  = 1'b0;
                     deb_n   = '0;
                     col_n   = col + 2'd1;
                     state_n = SCAN;
                  end
               end else begin
                  deb_n   = '0;
                  state_n = PRESSED;
               end
            end
            default: state_n = SCAN;
         endcase
      end
      if (accept) begin
         code_n  = {acc_row, col};
         valid_n = 1'b1;
         down_n  = 1'b1;
         if ({acc_row, col} == MKEY) mode_n = ~mode;
      end
   end

   // State and datapath registers.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state     <= SCAN;
         col       <= '0;
         row_sel   <= '0;
         deb       <= '0;
         key_code  <= '0;
         key_valid <= 1'b0;
         key_down  <= 1'b0;
         mode      <= 1'b0;
      end else begin
         state     <= state_n;
         col       <= col_n;
         row_sel   <= row_sel_n;
         deb       <= deb_n;
         key_code  <= code_n;
         key_valid <= valid_n;
         key_down  <= down_n;
         mode      <= mode_n;
      end
   end

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Scoreboard bench for keypad_scan_ctrl: a keypad matrix model drives the rows,
// expected {code, mode} pairs are queued per intended press and a monitor
// pops them whenever key_valid strobes.
module tb_keypad_scan_ctrl;

   logic       clk = 1'b0;
   logic       rstn = 1'b0;
   logic [3:0] row_in;
   logic [3:0] col_out;
   logic [3:0] key_code;
   logic       key_valid;
   logic       key_down;
   logic       mode;

   logic [15:0] keys = '0;      // keys[row*4+col] = pressed
   logic        mode_m = 1'b0;  // reference mode
   int unsigned cyc = 0;
   int          checks = 0;
   int          failures = 0;

   typedef struct packed {logic [3:0] code; logic md;} exp_t;
   exp_t expq[$];

   keypad_scan_ctrl #(.SCAN_DIV(4), .DEB_CNT(3), .MODE_KEY(15)) dut (
      .clk(clk), .rstn(rstn), .row_in(row_in), .col_out(col_out),
      .key_code(key_code), .key_valid(key_valid), .key_down(key_down), .mode(mode)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Keypad matrix: a pressed key pulls its row low while its column is driven.
   always_comb begin
      row_in = 4'hF;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            if (keys[r*4+c] && !col_out[c]) row_in[r] = 1'b0;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // Monitor: column drive sanity and scoreboard pop on every strobe.
   always @(negedge clk) begin
      exp_t e;
      if (rstn) begin
         check("col_onehot", {31'd0, $onehot(~col_out)}, 32'd1);
         if (key_valid) begin
            if (expq.size() == 0) begin
               check("unexpected_valid", {28'd0, key_code}, 32'hFFFF_FFFF);
            end else begin
               e = expq.pop_front();
               check("key_code", {28'd0, key_code}, {28'd0, e.code});
               check("mode", {31'd0, mode}, {31'd0, e.md});
               check("down_at_valid", {31'd0, key_down}, 32'd1);
            end
         end
      end
   end

   task automatic expect_press(input logic [3:0] code);
      if (code == 4'd15) mode_m = ~mode_m;
      expq.push_back('{code: code, md: mode_m});
   endtask

   task automatic wait_col(input int unsigned c);
      logic [3:0] p;
      int unsigned n;
      p = ~(4'b0001 << c);
      n = 0;
      while (col_out == p && n < 64) begin @(negedge clk); n++; end
      while (col_out != p && n < 128) begin @(negedge clk); n++; end
      if (col_out != p) check("wait_col_timeout", {28'd0, col_out}, {28'd0, p});
   endtask

   task automatic wait_valid(input int unsigned limit);
      int unsigned n;
      n = 0;
      while (!key_valid && n < limit) begin @(negedge clk); n++; end
      if (!key_valid) check("wait_valid_timeout", 32'd0, 32'd1);
   endtask

   task automatic wait_down_low(input int unsigned limit);
      int unsigned n;
      n = 0;
      while (key_down && n < limit) begin @(negedge clk); n++; end
      if (key_down) check("wait_release_timeout", 32'd1, 32'd0);
   endtask

   task automatic do_press(input logic [15:0] k, input logic [3:0] code);
      expect_press(code);
      keys = k;
      wait_valid(200);
      repeat (8) @(negedge clk);
      keys = '0;
      wait_down_low(200);
      repeat (4) @(negedge clk);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog_timeout cyc=%0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int unsigned t0, tv, b;
      int unsigned code;
      logic ok;

      // 1. Reset values and column rotation
      repeat (5) @(negedge clk);
      check("rst_col", {28'd0, col_out}, 32'hE);
      check("rst_code", {28'd0, key_code}, 32'd0);
      check("rst_valid", {31'd0, key_valid}, 32'd0);
      check("rst_down", {31'd0, key_down}, 32'd0);
      check("rst_mode", {31'd0, mode}, 32'd0);
      rstn = 1'b1;
      b = cyc;
      ok = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (col_out != ~(4'b0001 << (((cyc - b) / 4) % 4))) ok = 1'b0;
      end
      check("col_rotation", {31'd0, ok}, 32'd1);

      // 2. Clean press of row 2 / column 1 with exact latencies
      wait_col(1);
      t0 = cyc;
      expect_press(4'd9);
      keys[9] = 1'b1;
      wait_valid(100);
      tv = cyc;
      check("press_latency", tv - t0, 32'd12);
      repeat (28) @(negedge clk);
      keys = '0;
      repeat (11) @(negedge clk);
      check("down_before_release", {31'd0, key_down}, 32'd1);
      @(negedge clk);
      check("down_after_release", {31'd0, key_down}, 32'd0);
      check("resume_col2", {28'd0, col_out}, 32'hB);

      // 3a. Press bounce: low for one tick only
      wait_col(1);
      t0 = cyc;
      keys[9] = 1'b1;
      repeat (5) @(negedge clk);
      keys = '0;
      repeat (3) @(negedge clk);
      check("bounce_col_adv", {28'd0, col_out}, 32'hB);
      check("bounce_no_down", {31'd0, key_down}, 32'd0);
      repeat (4) @(negedge clk);
      check("bounce_scan_resumed", {28'd0, col_out}, 32'h7);

      // 3b. Release bounce: high for one tick, then held again
      wait_col(1);
      expect_press(4'd9);
      keys[9] = 1'b1;
      wait_valid(100);
      repeat (8) @(negedge clk);
      keys = '0;
      repeat (4) @(negedge clk);
      keys[9] = 1'b1;
      ok = 1'b1;
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         if (!key_down) ok = 1'b0;
      end
      check("rel_bounce_down_held", {31'd0, ok}, 32'd1);
      keys = '0;
      wait_down_low(100);
      repeat (4) @(negedge clk);

      // 4. Mode key twice, then a non-mode key
      do_press(16'h8000, 4'd15);
      check("mode_after_1st", {31'd0, mode}, 32'd1);
      do_press(16'h8000, 4'd15);
      check("mode_after_2nd", {31'd0, mode}, 32'd0);
      do_press(16'h0020, 4'd5);
      check("mode_after_key5", {31'd0, mode}, 32'd0);

      // 5. Rows 1 and 3 on column 0 together: lowest row wins
      do_press(16'h1010, 4'd4);

      // 6. Reset during press debounce, key still held across reset release
      wait_col(1);
      t0 = cyc;
      keys[9] = 1'b1;
      repeat (9) @(negedge clk);
      rstn = 1'b0;
      @(negedge clk);
      check("midrst_col", {28'd0, col_out}, 32'hE);
      check("midrst_code", {28'd0, key_code}, 32'd0);
      check("midrst_valid", {31'd0, key_valid}, 32'd0);
      check("midrst_down", {31'd0, key_down}, 32'd0);
      check("midrst_mode", {31'd0, mode}, 32'd0);
      repeat (4) @(negedge clk);
      mode_m = 1'b0;
      rstn = 1'b1;
      b = cyc;
      expect_press(4'd9);
      wait_valid(100);
      check("post_rst_latency", cyc - b, 32'd16);
      keys = '0;
      wait_down_low(100);
      repeat (4) @(negedge clk);

      // Randomised single-key presses, some preceded by a short glitch
      for (int i = 0; i < 24; i++) begin
         code = $urandom_range(0, 15);
         if ($urandom_range(0, 2) == 0) begin
            keys[code] = 1'b1;
            repeat ($urandom_range(1, 2)) @(negedge clk);
            keys = '0;
            repeat (10) @(negedge clk);
         end
         expect_press(4'(code));
         keys[code] = 1'b1;
         wait_valid(200);
         repeat ($urandom_range(0, 15)) @(negedge clk);
         keys = '0;
         wait_down_low(200);
         repeat ($urandom_range(0, 8)) @(negedge clk);
      end

      repeat (20) @(negedge clk);
      check("queue_drained", expq.size(), 32'd0);
      check("final_mode", {31'd0, mode}, {31'd0, mode_m});
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
